aes_inv_key_scheduler: RTL and testbench



---
 rtl/aes_inv_key_scheduler_pkg.sv | 62 ++++++
 rtl/aes_inv_key_scheduler_inv_key_step.sv | 30 +++
 rtl/aes_inv_key_scheduler.sv | 110 +++++++++++
 tb/tb_aes_inv_key_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_key_scheduler_pkg.sv
// Shared AES-128 key-schedule definitions: column/key types, S-box, round
// constants and the word-level helpers used by the forward and inverse steps.
package aes_inv_key_scheduler_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_BITS   = 128;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] keyColumn_t;
  // Element 3 is column 0 (bits [127:96]); element 0 is column 3.
  typedef keyColumn_t [3:0] roundKey_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    STREAM  = 2'd2
  } state_t;

  localparam byte_t SBOX [16][16] = '{
    '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76},
    '{8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0},
    '{8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15},
    '{8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75},
    '{8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84},
    '{8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf},
    '{8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8},
    '{8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2},
    '{8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73},
    '{8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb},
    '{8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79},
    '{8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08},
    '{8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a},
    '{8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e},
    '{8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf},
    '{8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16}
  };

  localparam byte_t RCON [11] = '{
    8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic byte_t sub_byte(input byte_t b);
    return SBOX[b[7:4]][b[3:0]];
  endfunction

  function automatic keyColumn_t rot_word(input keyColumn_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic keyColumn_t sub_word(input keyColumn_t w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  // Counter values past the last round only occur outside FORWARD/STREAM.
  function automatic byte_t rcon_for(input logic [3:0] round);
    if (round > 4'(NUM_ROUNDS)) begin
      return 8'h00;
    end
    return RCON[round];
  endfunction

endpackage

// File: rtl/aes_inv_key_scheduler_inv_key_step.sv
// Inverse AES-128 key expansion step: recovers round key i-1 from round key i
// given RCON[i].
module aes_inv_key_scheduler_inv_key_step
  import aes_inv_key_scheduler_pkg::*;
(
  input  roundKey_t next_key,
  input  byte_t     rcon,
  output roundKey_t prev_key
);

  keyColumn_t nxt_col [4];
  keyColumn_t prv_col [4];
  keyColumn_t prev_col3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cols
      assign nxt_col[gi]      = next_key[3-gi];
      assign prev_key[3-gi]   = prv_col[gi];
    end
    for (gi = 1; gi < 4; gi++) begin : g_xor
      assign prv_col[gi] = nxt_col[gi] ^ nxt_col[gi-1];
    end
  endgenerate

  // Column 0 depends on the recovered column 3, so derive it separately.
  assign prev_col3  = nxt_col[3] ^ nxt_col[2];
  assign prv_col[0] = nxt_col[0] ^ sub_word(rot_word(prev_col3)) ^ {rcon, 24'h0};

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// Iterative AES-128 reverse key scheduler: expands forward to round 10, then
// streams round keys 10..0 while regenerating each earlier key in place.
module aes_inv_key_scheduler
  import aes_inv_key_scheduler_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [KEY_BITS-1:0] rk_data,
  output logic [3:0]          rk_index,
  output logic                rk_last,
  output logic                busy
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_FORWARD  = FORWARD;
  localparam logic [1:0] S_STREAM   = STREAM;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  logic [1:0]  state_reg;
  roundKey_t   key_reg;
  logic [3:0]  round_reg;

  byte_t       rcon_cur;
  keyColumn_t  cur_col [4];
  keyColumn_t  fwd_col [4];
  roundKey_t   fwd_key;
  roundKey_t   prev_key;
  logic        in_stream;
  logic        rk_fire;

  assign rcon_cur  = rcon_for(round_reg);
  assign in_stream = (state_reg == S_STREAM);
  assign rk_fire   = in_stream && rk_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cols
      assign cur_col[gi]    = key_reg[3-gi];
      assign fwd_key[3-gi]  = fwd_col[gi];
    end
  endgenerate

  // Forward step: each column folds in the running XOR of the new columns.
  always_comb begin
    keyColumn_t acc;
    acc = cur_col[0] ^ sub_word(rot_word(cur_col[3])) ^ {rcon_cur, 24'h0};
    fwd_col[0] = acc;
    for (int i = 1; i < 4; i++) begin
      acc        = acc ^ cur_col[i];
      fwd_col[i] = acc;
    end
  end

  aes_inv_key_scheduler_inv_key_step u_inv_key_step (
    .next_key (key_reg),
    .rcon     (rcon_cur),
    .prev_key (prev_key)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      key_reg   <= '0;
      round_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (key_valid) begin
            key_reg   <= key_in;
            round_reg <= 4'd1;
            state_reg <= S_FORWARD;
          end
        end
        S_FORWARD: begin
          key_reg <= fwd_key;
          // The counter is left at 10 so it doubles as the first rk_index.
          if (round_reg == LAST_ROUND) begin
            state_reg <= S_STREAM;
          end else begin
            round_reg <= round_reg + 4'd1;
          end
        end
        S_STREAM: begin
          if (rk_fire) begin
            if (round_reg == 4'd0) begin
              state_reg <= S_IDLE;
            end else begin
              key_reg   <= prev_key;
              round_reg <= round_reg - 4'd1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign key_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign rk_valid  = in_stream;
  assign rk_data   = in_stream ? KEY_BITS'(key_reg) : '0;
  assign rk_index  = in_stream ? round_reg : 4'd0;
  assign rk_last   = in_stream && (round_reg == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Directed bench for the reverse key scheduler: known-answer table, a
// forward-expansion reference model, stalls, ignored keys and mid-stream reset.
module tb_aes_inv_key_scheduler;
  import aes_inv_key_scheduler_pkg::*;

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_ALT  = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         busy;

  always #5 clock = ~clock;

  aes_inv_key_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  vec_t         vecs [5];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];
  logic [7:0]   tb_rcon [11] = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[b[7:4]][b[3:0]];
  endfunction

  task automatic compute_exp(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    exp_rk[0] = k;
    for (int r = 1; r <= 10; r++) begin
      t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {tb_rcon[r], 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      exp_rk[r] = {w0, w1, w2, w3};
    end
  endtask

  // Call at a negedge with the block idle; returns at the negedge where rk_valid is first seen.
  task automatic send_key(input logic [127:0] k, input bit hold);
    int cycles;
    compute_exp(k);
    key_in    = k;
    key_valid = 1'b1;
    check("key_ready_before_accept", key_ready, 1'b1);
    @(posedge clock);
    cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (hold) key_in = KEY_ALT;
      else key_valid = 1'b0;
      if (rk_valid) break;
      if (c < 3 || hold) check("key_ready_low_forward", key_ready, 1'b0);
      @(posedge clock);
      cycles++;
    end
    check("latency_cycles", cycles, 10);
    $display("[TB] key %h accepted, first round key after %0d cycles", k, cycles);
  endtask

  task automatic collect(input bit random_ready, input bit hold, input int stop_at);
    int n, iters;
    bit stalled, r;
    logic [127:0] held_data;
    logic [3:0]   held_idx;
    n = 0; iters = 0; stalled = 0; held_data = '0; held_idx = '0;
    while (n < 11 && iters < 400) begin
      iters++;
      check("rk_valid_in_stream", rk_valid, 1'b1);
      if (rk_valid) begin
        if (stop_at >= 0 && int'(rk_index) == stop_at) begin
          rk_ready = 1'b0;
          break;
        end
        if (stalled) begin
          check("stall_data_stable", rk_data, held_data);
          check("stall_index_stable", rk_index, held_idx);
        end
        if (hold) check("key_ready_low_stream", key_ready, 1'b0);
        r = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        rk_ready = r;
        if (r) begin
          check($sformatf("rk_index_beat%0d", n), rk_index, 10 - n);
          check($sformatf("rk_data_r%0d", 10 - n), rk_data, exp_rk[10 - n]);
          check($sformatf("rk_last_beat%0d", n), rk_last, (n == 10));
          $display("[TB] beat idx=%0d data=%h last=%0b", rk_index, rk_data, rk_last);
          got_rk[10 - n] = rk_data;
          n++;
          stalled = 0;
          if (n == 11 && hold) key_valid = 1'b0;
        end else begin
          stalled   = 1;
          held_data = rk_data;
          held_idx  = rk_index;
        end
      end
      if (n < 11) @(negedge clock);
    end
    if (stop_at >= 0) begin
      check("stop_index_reached", rk_index, stop_at);
    end else begin
      check("all_beats_done", n, 11);
      if (!random_ready) check("beats_consecutive", iters, 11);
      @(negedge clock);
      check("rk_valid_after_last", rk_valid, 1'b0);
      check("key_ready_after_last", key_ready, 1'b1);
      check("busy_after_last", busy, 1'b0);
    end
  endtask

  task automatic table_check(input logic [127:0] k);
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].key == k) begin
        check($sformatf("table_%0d_idx%0d", i, vecs[i].idx), got_rk[vecs[i].idx], vecs[i].rk);
      end
    end
  endtask

  initial begin
    vecs[0] = '{key: KEY_FIPS, idx: 10, rk: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{key: KEY_FIPS, idx: 1,  rk: 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{key: KEY_FIPS, idx: 0,  rk: 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[3] = '{key: KEY_SEQ,  idx: 10, rk: 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[4] = '{key: KEY_SEQ,  idx: 0,  rk: 128'h000102030405060708090a0b0c0d0e0f};

    @(negedge clock);
    check("reset_key_ready", key_ready, 1'b1);
    check("reset_rk_valid", rk_valid, 1'b0);
    check("reset_rk_data", rk_data, '0);
    check("reset_rk_index", rk_index, 4'd0);
    check("reset_rk_last", rk_last, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // FIPS-197 key with the consumer always ready.
    send_key(KEY_FIPS, 1'b0);
    collect(1'b0, 1'b0, -1);
    table_check(KEY_FIPS);

    // Same key with random back-pressure; accepted right after the previous rk_last.
    send_key(KEY_FIPS, 1'b0);
    collect(1'b1, 1'b0, -1);
    table_check(KEY_FIPS);

    send_key(KEY_SEQ, 1'b0);
    collect(1'b0, 1'b0, -1);
    table_check(KEY_SEQ);

    // key_valid held with a different key while busy must be ignored.
    send_key(KEY_FIPS, 1'b1);
    collect(1'b0, 1'b1, -1);
    table_check(KEY_FIPS);

    // Asynchronous reset at stream index 6.
    send_key(KEY_FIPS, 1'b0);
    collect(1'b0, 1'b0, 6);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rk_valid", rk_valid, 1'b0);
    check("async_rst_key_ready", key_ready, 1'b1);
    check("async_rst_rk_data", rk_data, '0);
    check("async_rst_rk_index", rk_index, 4'd0);
    check("async_rst_busy", busy, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_rk_valid", rk_valid, 1'b0);
    send_key(KEY_SEQ, 1'b0);
    collect(1'b0, 1'b0, -1);
    table_check(KEY_SEQ);

    // Back-to-back accept immediately after the rk_last handshake.
    send_key(KEY_FIPS, 1'b0);
    collect(1'b0, 1'b0, -1);
    table_check(KEY_FIPS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, required completion");
    $fatal(1, "global timeout");
  end

endmodule
